// File: rtl/axis_video_frame_ctrl.sv
// axis_video_frame_ctrl
//   Frames RGB444 renderer pixels into an AXI4-Stream video stream.
//   Pixels are expanded to 24-bit {R8,B8,G8}. Each frame is exactly
//   H_ACTIVE x V_ACTIVE beats. The first beat of a frame carries tuser,
//   and the last beat of each line carries tlast.
//   The controller arms while enable is high and starts a frame on a
//   frame_start pulse. It counts completed frames and starved cycles, and
//   flags a frame_start that arrives while a frame is in progress.
// Ports:
//   clk, reset               pixel clock, async active-high reset
//   enable, frame_start      arm level / frame start pulse
//   pix_data/valid/ready     renderer side (RGB444 {R4,G4,B4})
//   m_tdata/tvalid/tready    stream side, plus m_tuser (SOF), m_tlast (EOL)
//   busy                     frame in progress (streaming or draining)
//   frame_count              completed frames, wraps
//   stall_count              starved streaming cycles, saturates
//   resync_err               sticky mid-frame frame_start flag
module axis_video_frame_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_start,
  input  logic [11:0]      pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [23:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             resync_err
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_STREAM, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [23:0]        tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tuser_q, tuser_d;
  logic               tlast_q, tlast_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               resync_q, resync_d;

  logic               ready_c;
  logic               accept;
  logic               hs;
  logic               x_end;
  logic               y_end;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    frame_d  = frame_q;
    stall_d  = stall_q;
    resync_d = resync_q;

    // The output register can take a pixel when it is empty or is being
    // emptied in this same cycle. pix_valid is deliberately not an input.
    ready_c = (state_q == ST_STREAM) && (!tvalid_q || m_tready);
    accept  = pix_valid && ready_c;
    hs      = tvalid_q && m_tready;
    x_end   = (x_q == XW'(H_ACTIVE - 1));
    y_end   = (y_q == YW'(V_ACTIVE - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          state_d = ST_STREAM;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_STREAM: begin
        if (accept && x_end && y_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Only the final beat of the frame can be in the register here.
        if (hs) begin
          state_d = enable ? ST_ARMED : ST_IDLE;
          frame_d = frame_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs) tvalid_d = 1'b0;

    // A new pixel overrides the handshake clear, so reloads have no bubble.
    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = {pix_data[11:8], pix_data[11:8],
                  pix_data[3:0],  pix_data[3:0],
                  pix_data[7:4],  pix_data[7:4]};
      tuser_d  = (x_q == '0) && (y_q == '0);
      tlast_d  = x_end;
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (ready_c && !pix_valid && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);

    if (frame_start && ((state_q == ST_STREAM) || (state_q == ST_DRAIN)))
      resync_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      frame_q  <= '0;
      stall_q  <= '0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      frame_q  <= frame_d;
      stall_q  <= stall_d;
      resync_q <= resync_d;
    end
  end

  assign pix_ready   = ready_c;
  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tuser     = tuser_q;
  assign m_tlast     = tlast_q;
  assign busy        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign frame_count = frame_q;
  assign stall_count = stall_q;
  assign resync_err  = resync_q;

endmodule

// File: tb/tb_axis_video_frame_ctrl.sv
// Testbench for axis_video_frame_ctrl using a small 4x3 frame and 4-bit counters.
module tb_axis_video_frame_ctrl;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int CW   = 4;
  localparam int NSRC = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          frame_start;
  logic [11:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [23:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tuser;
  logic          m_tlast;
  logic          busy;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] stall_count;
  logic          resync_err;

  always #5 clk = ~clk;

  axis_video_frame_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_start(frame_start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .frame_count(frame_count),
    .stall_count(stall_count),
    .resync_err (resync_err)
  );

  typedef struct {
    logic [11:0] pix;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  vec_t        vtab [6];
  beat_t       sb [$];
  logic [11:0] src_pix [NSRC];
  logic [23:0] src_exp [NSRC];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats = 0;
  int acc_total = 0;
  int pix_idx = 0;
  bit acc_seen = 1'b0;
  int tr_mode = 0;
  int tr_ph = 0;
  int mx = 0;
  int my = 0;
  int hs_cyc [12];

  function automatic logic [23:0] expand(input logic [11:0] p);
    return {p[11:8], p[11:8], p[3:0], p[3:0], p[7:4], p[7:4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Pixel source and downstream ready pattern, updated just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (acc_seen) begin
      pix_idx++;
      acc_seen = 1'b0;
    end
    pix_data = src_pix[pix_idx % NSRC];
    tr_ph++;
    m_tready = (tr_mode == 0) ? 1'b1 : ((tr_ph % 3) == 0);
  end

  // Monitor on the falling edge: beats offered now transfer on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_tvalid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard (t=%0t)", m_tdata, $time);
        end else begin
          chk("beat_data", m_tdata, sb[0].d);
          chk("beat_tuser", m_tuser, sb[0].u);
          chk("beat_tlast", m_tlast, sb[0].l);
          if (m_tready) begin
            void'(sb.pop_front());
            if (beats < 12) hs_cyc[beats] = cyc;
            beats++;
          end
        end
        if (!m_tready) chk("stall_pix_ready", pix_ready, 0);
      end
      if (pix_valid && pix_ready) begin
        sb.push_back('{src_exp[pix_idx % NSRC], (mx == 0 && my == 0), (mx == H - 1)});
        if (mx == H - 1) begin
          mx = 0;
          my = (my == V - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        acc_total++;
        acc_seen = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    enable = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 400; i++) begin
      if (beats >= n) break;
      tick();
    end
    if (beats < n) begin
      total++;
      bad++;
      $display("FAIL wait_beats: got %0d beats expected %0d", beats, n);
    end
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 400; i++) begin
      if (acc_total >= n) break;
      tick();
    end
    if (acc_total < n) begin
      total++;
      bad++;
      $display("FAIL wait_acc: got %0d accepts expected %0d", acc_total, n);
    end
  endtask

  task automatic gap(input int n);
    pix_valid = 1'b0;
    repeat (n) tick();
    pix_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset       = 1'b1;
    enable      = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    m_tready    = 1'b1;

    vtab[0] = '{12'hF80, 24'hFF0088};
    vtab[1] = '{12'h123, 24'h113322};
    vtab[2] = '{12'h0FF, 24'h00FFFF};
    vtab[3] = '{12'h000, 24'h000000};
    vtab[4] = '{12'hFFF, 24'hFFFFFF};
    vtab[5] = '{12'hA5C, 24'hAACC55};
    for (int i = 0; i < 6; i++) begin
      src_pix[i] = vtab[i].pix;
      src_exp[i] = vtab[i].exp;
    end
    for (int i = 6; i < NSRC; i++) begin
      src_pix[i] = 12'($urandom);
      src_exp[i] = expand(src_pix[i]);
    end
    pix_data = src_pix[0];

    repeat (2) tick();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_resync", resync_err, 0);
    reset = 1'b0;
    pix_valid = 1'b1;

    // Frame 1: full rate, table pixels lead the frame.
    start_frame();
    chk("f1_busy_start", busy, 1);
    wait_beats(12);
    chk("f1_back_to_back", hs_cyc[11] - hs_cyc[0], 11);
    chk("f1_frame_count", frame_count, 1);
    chk("f1_busy_end", busy, 0);
    chk("f1_armed_not_ready", pix_ready, 0);
    chk("f1_stall_count", stall_count, 0);
    chk("f1_sb_empty", sb.size(), 0);

    // Frame 2: downstream backpressure pattern 1,0,0.
    tr_mode = 1;
    start_frame();
    wait_beats(24);
    tr_mode = 0;
    chk("f2_frame_count", frame_count, 2);
    chk("f2_stall_count", stall_count, 0);
    chk("f2_sb_empty", sb.size(), 0);

    // Frame 3: five starved cycles mid-line.
    start_frame();
    wait_acc(30);
    gap(5);
    wait_beats(36);
    chk("f3_stall_count", stall_count, 5);
    chk("f3_frame_count", frame_count, 3);

    // Frame 4: saturate the stall counter, then confirm it stays there.
    start_frame();
    wait_acc(42);
    gap(20);
    chk("f4_stall_sat", stall_count, 15);
    wait_acc(45);
    gap(3);
    wait_beats(48);
    chk("f4_stall_hold", stall_count, 15);
    chk("f4_frame_count", frame_count, 4);

    // Frame 5: mid-frame frame_start, then enable drops; frame still completes.
    start_frame();
    wait_acc(54);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f5_resync_set", resync_err, 1);
    chk("f5_busy_mid", busy, 1);
    wait_acc(56);
    enable = 1'b0;
    wait_beats(60);
    chk("f5_frame_count", frame_count, 5);
    chk("f5_busy_end", busy, 0);
    chk("f5_resync_sticky", resync_err, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (10) tick();
    chk("f5_idle_ignore_busy", busy, 0);
    chk("f5_idle_ignore_beats", beats, 60);
    chk("f5_idle_not_ready", pix_ready, 0);

    // Frames 6..16: frame counter wraps modulo 16.
    for (int f = 0; f < 11; f++) begin
      start_frame();
      wait_beats(60 + 12 * (f + 1));
    end
    chk("wrap_frame_count", frame_count, 0);
    chk("wrap_resync_sticky", resync_err, 1);

    // Async reset with a beat in flight, then a fresh frame.
    start_frame();
    wait_beats(197);
    chk("rst_mid_precond_tvalid", m_tvalid, 1);
    #2;
    sb.delete();
    mx = 0;
    my = 0;
    reset = 1'b1;
    #1;
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_frame_count", frame_count, 0);
    chk("rst_mid_stall_count", stall_count, 0);
    chk("rst_mid_resync", resync_err, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pix_ready", pix_ready, 0);
    repeat (2) tick();
    reset = 1'b0;
    base = beats;
    start_frame();
    wait_beats(base + 12);
    chk("post_rst_frame_count", frame_count, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
